// File: rtl/fp_trace_writer.sv
// fp_trace_writer: in-order trace buffer that pairs fp_unit requests with their responses and
// emits 288-bit fpu.dat records. Optional macro FP_TRACE_NAN_CANON_EN canonicalises NaN results.
module fp_trace_writer #(
  parameter int DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [63:0]             req_data1,
  input  logic [63:0]             req_data2,
  input  logic [63:0]             req_data3,
  input  logic [1:0]              req_fmt,
  input  logic [2:0]              req_rm,
  input  logic [1:0]              req_op,
  input  logic [9:0]              req_opcode,
  input  logic                    req_last,
  output logic                    req_accept,
  input  logic                    rsp_ready,
  input  logic [63:0]             rsp_result,
  input  logic [4:0]              rsp_flags,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [287:0]            rec_data,
  output logic [$clog2(DEPTH):0]  inflight,
  output logic [15:0]             drop_count,
  output logic                    err_overflow,
  output logic                    err_orphan,
  output logic                    done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0] r_data1  [DEPTH];
  logic [63:0] r_data2  [DEPTH];
  logic [63:0] r_data3  [DEPTH];
  logic [1:0]  r_fmt    [DEPTH];
  logic [2:0]  r_rm     [DEPTH];
  logic [1:0]  r_op     [DEPTH];
  logic [9:0]  r_opcode [DEPTH];
  logic        r_last   [DEPTH];
  logic [63:0] r_result [DEPTH];
  logic [4:0]  r_flags  [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_cmp;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_numCompleted;
  logic [15:0]   r_dropCount;
  logic          r_errOverflow;
  logic          r_errOrphan;
  logic          r_done;

  logic          w_issue;
  logic          w_drop;
  logic          w_complete;
  logic          w_orphan;
  logic          w_emit;
  logic          w_hasOutstanding;
  logic [63:0]   w_resultStore;
  logic [1:0]    w_cmpFmt;

  // Completed-but-unemitted entries are counted separately so a full buffer stays unambiguous.
  assign req_accept       = (r_count < CW'(DEPTH));
  assign rec_valid        = (r_numCompleted != '0);
  assign w_hasOutstanding = (r_count != r_numCompleted);
  assign w_issue          = req_valid && req_accept;
  assign w_drop           = req_valid && !req_accept;
  assign w_complete       = rsp_ready && w_hasOutstanding;
  assign w_orphan         = rsp_ready && !w_hasOutstanding;
  assign w_emit           = rec_valid && rec_ready;
  assign w_cmpFmt         = r_fmt[r_cmp];

`ifdef FP_TRACE_NAN_CANON_EN
  logic [9:0] w_cmpOpcode;
  logic       w_isNan32;
  logic       w_isNan64;

  assign w_cmpOpcode = r_opcode[r_cmp];
  assign w_isNan32   = (rsp_result[30:23] == 8'hFF) && (rsp_result[22:0] != 23'd0);
  assign w_isNan64   = (rsp_result[62:52] == 11'h7FF) && (rsp_result[51:0] != 52'd0);

  // Integer-producing ops (fcvt_f2i, fcmp) keep their raw result.
  always_comb begin
    w_resultStore = (w_cmpFmt == 2'd0) ? {32'd0, rsp_result[31:0]} : rsp_result;
    if (!w_cmpOpcode[9] && !w_cmpOpcode[6]) begin
      if ((w_cmpFmt == 2'd0) && w_isNan32) begin
        w_resultStore = 64'h0000_0000_7FC0_0000;
      end else if ((w_cmpFmt != 2'd0) && w_isNan64) begin
        w_resultStore = 64'h7FF8_0000_0000_0000;
      end
    end
  end
`else
  always_comb begin
    w_resultStore = (w_cmpFmt == 2'd0) ? {32'd0, rsp_result[31:0]} : rsp_result;
  end
`endif

  always_ff @(posedge clock) begin
    if (w_issue) begin
      r_data1[r_tail]  <= req_data1;
      r_data2[r_tail]  <= req_data2;
      r_data3[r_tail]  <= req_data3;
      r_fmt[r_tail]    <= req_fmt;
      r_rm[r_tail]     <= req_rm;
      r_op[r_tail]     <= req_op;
      r_opcode[r_tail] <= req_opcode;
      r_last[r_tail]   <= req_last;
    end
    if (w_complete) begin
      r_result[r_cmp] <= w_resultStore;
      r_flags[r_cmp]  <= rsp_flags;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head         <= '0;
      r_cmp          <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_numCompleted <= '0;
      r_dropCount    <= '0;
      r_errOverflow  <= 1'b0;
      r_errOrphan    <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      if (w_issue)    r_tail <= r_tail + 1'b1;
      if (w_complete) r_cmp  <= r_cmp + 1'b1;
      if (w_emit)     r_head <= r_head + 1'b1;
      r_count        <= r_count + CW'(w_issue) - CW'(w_emit);
      r_numCompleted <= r_numCompleted + CW'(w_complete) - CW'(w_emit);
      if (w_drop) begin
        r_errOverflow <= 1'b1;
        if (r_dropCount != 16'hFFFF) r_dropCount <= r_dropCount + 16'd1;
      end
      if (w_orphan) r_errOrphan <= 1'b1;
      if (w_emit && r_last[r_head]) r_done <= 1'b1;
    end
  end

  assign rec_data = rec_valid ?
    {r_data1[r_head], r_data2[r_head], r_data3[r_head], r_result[r_head],
     3'b000, r_flags[r_head], 2'b00, r_fmt[r_head], 1'b0, r_rm[r_head],
     2'b00, r_op[r_head], 2'b00, r_opcode[r_head]} : '0;

  assign inflight     = r_count;
  assign drop_count   = r_dropCount;
  assign err_overflow = r_errOverflow;
  assign err_orphan   = r_errOrphan;
  assign done         = r_done;

endmodule

// File: tb/tb_fp_trace_writer.sv
// Scoreboard bench for fp_trace_writer: requests queue up, responses turn them into expected
// records, and every record handshake is compared against the head of the expected queue.
module tb_fp_trace_writer;

  typedef struct {
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] d3;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [1:0]  op;
    logic [9:0]  opc;
  } req_t;

`ifdef FP_TRACE_NAN_CANON_EN
  localparam bit CANON = 1'b1;
`else
  localparam bit CANON = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic [63:0]  req_data1 = '0;
  logic [63:0]  req_data2 = '0;
  logic [63:0]  req_data3 = '0;
  logic [1:0]   req_fmt = '0;
  logic [2:0]   req_rm = '0;
  logic [1:0]   req_op = '0;
  logic [9:0]   req_opcode = '0;
  logic         req_last = 1'b0;
  logic         req_accept;
  logic         rsp_ready = 1'b0;
  logic [63:0]  rsp_result = '0;
  logic [4:0]   rsp_flags = '0;
  logic         rec_valid;
  logic         rec_ready = 1'b0;
  logic [287:0] rec_data;
  logic [3:0]   inflight;
  logic [15:0]  drop_count;
  logic         err_overflow;
  logic         err_orphan;
  logic         done;

  int checks = 0;
  int errors = 0;
  int recCount = 0;
  req_t pendQ[$];
  logic [287:0] expQ[$];

  fp_trace_writer #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
    .req_fmt(req_fmt), .req_rm(req_rm), .req_op(req_op), .req_opcode(req_opcode),
    .req_last(req_last), .req_accept(req_accept),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .inflight(inflight), .drop_count(drop_count),
    .err_overflow(err_overflow), .err_orphan(err_orphan), .done(done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [287:0] observed, input logic [287:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference result as the trace file should hold it, from the format rules alone.
  function automatic logic [63:0] modelResult(input logic [9:0] opc, input logic [1:0] fmt, input logic [63:0] r);
    logic [63:0] v;
    v = (fmt == 2'd0) ? {32'd0, r[31:0]} : r;
    if (CANON && !opc[9] && !opc[6]) begin
      if (fmt == 2'd0 && r[30:23] == 8'hFF && r[22:0] != 23'd0) v = 64'h7FC00000;
      else if (fmt != 2'd0 && r[62:52] == 11'h7FF && r[51:0] != 52'd0) v = 64'h7FF8000000000000;
    end
    return v;
  endfunction

  // Every record handshake is checked against the oldest expected record.
  always @(negedge clock) begin
    if (!reset && rec_valid && rec_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedRecord", 288'd1, 288'd0);
      end else begin
        checkOutput("record", rec_data, expQ.pop_front());
        recCount++;
      end
    end
  end

  task automatic resetDut(input int cycles);
    reset = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
    pendQ.delete();
    expQ.delete();
  endtask

  task automatic applyStimulus(input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3,
                               input logic [1:0] fmt, input logic [2:0] rm, input logic [1:0] op,
                               input logic [9:0] opc, input logic last, input bit expAccept);
    req_t r;
    r.d1 = d1; r.d2 = d2; r.d3 = d3; r.fmt = fmt; r.rm = rm; r.op = op; r.opc = opc;
    req_valid = 1'b1;
    req_data1 = d1; req_data2 = d2; req_data3 = d3;
    req_fmt = fmt; req_rm = rm; req_op = op; req_opcode = opc; req_last = last;
    if (expAccept) pendQ.push_back(r);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_last = 1'b0;
  endtask

  task automatic respond(input logic [63:0] result, input logic [4:0] flags);
    req_t r;
    rsp_ready = 1'b1;
    rsp_result = result;
    rsp_flags = flags;
    if (pendQ.size() == 0) begin
      checkOutput("respondWithoutRequest", 288'd1, 288'd0);
    end else begin
      r = pendQ.pop_front();
      expQ.push_back({r.d1, r.d2, r.d3, modelResult(r.opc, r.fmt, result), 3'b000, flags,
                      2'b00, r.fmt, 1'b0, r.rm, 2'b00, r.op, 2'b00, r.opc});
    end
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic orphanRsp();
    rsp_ready = 1'b1;
    rsp_result = 64'hDEAD;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic drain(input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("drainRemaining", expQ.size(), 0);
  endtask

  initial begin
    int startRecs;

    // Reset state
    resetDut(2);
    checkOutput("resetRecValid", rec_valid, 0);
    checkOutput("resetRecData", rec_data, 0);
    checkOutput("resetInflight", inflight, 0);
    checkOutput("resetDropCount", drop_count, 0);
    checkOutput("resetFlags", {err_overflow, err_orphan, done}, 0);
    checkOutput("resetAccept", req_accept, 1);

    // Single fadd, response four cycles after issue
    $display("[TB] single fadd");
    rec_ready = 1'b1;
    applyStimulus(64'h3F800000, 64'h40000000, 64'h0, 2'd0, 3'd0, 2'd0, 10'h002, 1'b0, 1'b1);
    checkOutput("t1InflightIssued", inflight, 1);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("t1NoRecYet", rec_valid, 0);
    respond(64'h40400000, 5'd0);
    checkOutput("t1RecValid", rec_valid, 1);
    checkOutput("t1Result", rec_data[95:32], 64'h40400000);
    checkOutput("t1Opcode", rec_data[9:0], 10'h002);
    checkOutput("t1Flags", rec_data[28:24], 0);
    @(posedge clock);
    #1;
    checkOutput("t1InflightEmpty", inflight, 0);
    checkOutput("t1RecCount", recCount, 1);

    // Fill with the sink stalled, overflow once, then drain in order
    $display("[TB] fill and overflow");
    rec_ready = 1'b0;
    for (int k = 1; k <= 8; k++)
      applyStimulus(64'(k), 64'(k * 3), 64'h55, 2'd1, 3'(k), 2'(k), 10'h004, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++)
      respond(64'(k * 16) | 64'h4000_0000_0000_0000, 5'(k));
    checkOutput("t2Inflight", inflight, 8);
    checkOutput("t2AcceptLow", req_accept, 0);
    applyStimulus(64'd9, 64'd9, 64'd9, 2'd1, 3'd0, 2'd0, 10'h004, 1'b0, 1'b0);
    checkOutput("t2DropCount", drop_count, 1);
    checkOutput("t2Overflow", err_overflow, 1);
    checkOutput("t2InflightAfterDrop", inflight, 8);
    startRecs = recCount;
    rec_ready = 1'b1;
    drain(40);
    checkOutput("t2RecordsEmitted", recCount - startRecs, 8);
    checkOutput("t2InflightDrained", inflight, 0);

    // Orphan response on an empty buffer
    $display("[TB] orphan response");
    resetDut(1);
    checkOutput("t3OverflowCleared", err_overflow, 0);
    orphanRsp();
    checkOutput("t3Orphan", err_orphan, 1);
    checkOutput("t3RecValid", rec_valid, 0);
    checkOutput("t3Inflight", inflight, 0);

    // NaN results: arithmetic vs integer-producing ops, single and double, upper-half masking
    $display("[TB] nan handling");
    resetDut(1);
    rec_ready = 1'b1;
    applyStimulus(64'h1, 64'h2, 64'h0, 2'd0, 3'd1, 2'd0, 10'h002, 1'b0, 1'b1);
    applyStimulus(64'h3, 64'h4, 64'h0, 2'd0, 3'd2, 2'd1, 10'h200, 1'b0, 1'b1);
    applyStimulus(64'h5, 64'h6, 64'h7, 2'd1, 3'd3, 2'd0, 10'h001, 1'b0, 1'b1);
    applyStimulus(64'h8, 64'h9, 64'h0, 2'd0, 3'd4, 2'd0, 10'h008, 1'b0, 1'b1);
    respond(64'h7FC00001, 5'h10);
    checkOutput("t4Result", rec_data[95:32], CANON ? 64'h7FC00000 : 64'h7FC00001);
    respond(64'h7FC00001, 5'h01);
    respond(64'h7FF0000000000001, 5'h02);
    respond(64'hABCD1234_3F800000, 5'h00);
    drain(20);

    // Last-of-run with a sink that stalls two cycles per record
    $display("[TB] done flag");
    resetDut(1);
    rec_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      applyStimulus(64'(k + 100), 64'h0, 64'h0, 2'd1, 3'd0, 2'd0, 10'h010, (k == 2), 1'b1);
    for (int k = 0; k < 3; k++)
      respond(64'(k + 200), 5'd0);
    for (int k = 0; k < 3; k++) begin
      repeat (2) @(posedge clock);
      #1;
      checkOutput("t5DoneBeforeHs", done, 0);
      rec_ready = 1'b1;
      @(posedge clock);
      #1;
      rec_ready = 1'b0;
      checkOutput("t5DoneAfterHs", done, (k == 2));
    end
    checkOutput("t5AllEmitted", expQ.size(), 0);

    // Reset in the middle of activity
    $display("[TB] mid-operation reset");
    for (int k = 0; k < 3; k++)
      applyStimulus(64'(k + 300), 64'h0, 64'h0, 2'd0, 3'd0, 2'd0, 10'h002, 1'b0, 1'b1);
    respond(64'h1234, 5'd3);
    orphanRsp();
    checkOutput("t6InflightBefore", inflight, 3);
    checkOutput("t6OrphanBefore", err_orphan, 0);
    resetDut(1);
    checkOutput("t6RecValid", rec_valid, 0);
    checkOutput("t6Inflight", inflight, 0);
    checkOutput("t6DropCount", drop_count, 0);
    checkOutput("t6Flags", {err_overflow, err_orphan, done}, 0);
    checkOutput("t6RecData", rec_data, 0);
    rec_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("t6NoStaleRecord", rec_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
